// File: rtl/tbuart.sv
// Minimal 8N1 UART: transmitter with one-frame-per-request handshake and an
// optional receiver enabled by defining TBUART_RX_EN.
module tbuart #(
  parameter int CLKS_PER_BIT = 4167
) (
  input  logic       clock,
  input  logic       resetb,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       ser_tx,
  output logic       tx_busy,
  output logic       tx_clear_req,
  input  logic       ser_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err
);

  localparam logic [1:0]  S_IDLE  = 2'd0;
  localparam logic [1:0]  S_START = 2'd1;
  localparam logic [1:0]  S_DATA  = 2'd2;
  localparam logic [1:0]  S_STOP  = 2'd3;
  localparam logic [15:0] L_BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] L_HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

  logic [1:0]  r_tx_state;
  logic [15:0] r_tx_cnt;
  logic [2:0]  r_tx_bit;
  logic [7:0]  r_tx_shift;
  logic        r_armed;
  logic        r_ser_tx;
  logic        r_tx_busy;
  logic        r_tx_clear;
  logic        w_tx_bit_end;

  assign w_tx_bit_end = (r_tx_cnt == L_BIT_LAST);
  assign ser_tx       = r_ser_tx;
  assign tx_busy      = r_tx_busy;
  assign tx_clear_req = r_tx_clear;

  // Transmit FSM; armed re-arms whenever tx_start is seen low so a held request sends once.
  always_ff @(posedge clock) begin
    if (!resetb) begin
      r_tx_state <= S_IDLE;
      r_tx_cnt   <= 16'd0;
      r_tx_bit   <= 3'd0;
      r_tx_shift <= 8'h00;
      r_armed    <= 1'b1;
      r_ser_tx   <= 1'b1;
      r_tx_busy  <= 1'b0;
      r_tx_clear <= 1'b0;
    end else begin
      r_tx_clear <= 1'b0;
      if (!tx_start) begin
        r_armed <= 1'b1;
      end
      case (r_tx_state)
        S_IDLE: begin
          r_tx_cnt <= 16'd0;
          r_tx_bit <= 3'd0;
          if (tx_start && r_armed) begin
            r_tx_state <= S_START;
            r_tx_shift <= tx_data;
            r_ser_tx   <= 1'b0;
            r_tx_busy  <= 1'b1;
            r_armed    <= 1'b0;
          end
        end
        S_START: begin
          if (w_tx_bit_end) begin
            r_tx_state <= S_DATA;
            r_tx_cnt   <= 16'd0;
            r_ser_tx   <= r_tx_shift[0];
            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
          end else begin
            r_tx_cnt <= r_tx_cnt + 16'd1;
          end
        end
        S_DATA: begin
          if (w_tx_bit_end) begin
            r_tx_cnt <= 16'd0;
            if (r_tx_bit == 3'd7) begin
              r_tx_state <= S_STOP;
              r_ser_tx   <= 1'b1;
            end else begin
              r_tx_bit   <= r_tx_bit + 3'd1;
              r_ser_tx   <= r_tx_shift[0];
              r_tx_shift <= {1'b0, r_tx_shift[7:1]};
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + 16'd1;
          end
        end
        S_STOP: begin
          if (w_tx_bit_end) begin
            r_tx_state <= S_IDLE;
            r_tx_cnt   <= 16'd0;
            r_tx_busy  <= 1'b0;
            r_tx_clear <= 1'b1;
          end else begin
            r_tx_cnt <= r_tx_cnt + 16'd1;
          end
        end
        default: begin
          r_tx_state <= S_IDLE;
          r_ser_tx   <= 1'b1;
          r_tx_busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef TBUART_RX_EN
  logic [1:0]  r_rx_state;
  logic [15:0] r_rx_cnt;
  logic [2:0]  r_rx_bit;
  logic [7:0]  r_rx_shift;
  logic [7:0]  r_rx_data;
  logic        r_rx_valid;
  logic        r_rx_ferr;
  logic        r_rx_meta;
  logic        r_rx_sync;
  logic        r_rx_prev;
  logic        w_rx_bit_end;

  assign w_rx_bit_end = (r_rx_cnt == L_BIT_LAST);
  assign rx_data      = r_rx_data;
  assign rx_valid     = r_rx_valid;
  assign rx_frame_err = r_rx_ferr;

  // Receive path: 2-flop synchronizer, falling-edge detect, mid-bit sampling.
  always_ff @(posedge clock) begin
    if (!resetb) begin
      r_rx_state <= S_IDLE;
      r_rx_cnt   <= 16'd0;
      r_rx_bit   <= 3'd0;
      r_rx_shift <= 8'h00;
      r_rx_data  <= 8'h00;
      r_rx_valid <= 1'b0;
      r_rx_ferr  <= 1'b0;
      r_rx_meta  <= 1'b1;
      r_rx_sync  <= 1'b1;
      r_rx_prev  <= 1'b1;
    end else begin
      r_rx_meta  <= ser_rx;
      r_rx_sync  <= r_rx_meta;
      r_rx_prev  <= r_rx_sync;
      r_rx_valid <= 1'b0;
      r_rx_ferr  <= 1'b0;
      case (r_rx_state)
        S_IDLE: begin
          r_rx_cnt <= 16'd0;
          r_rx_bit <= 3'd0;
          if (r_rx_prev && !r_rx_sync) begin
            r_rx_state <= S_START;
          end
        end
        S_START: begin
          // A start bit that is high again at its midpoint was a glitch.
          if (r_rx_cnt == L_HALF_LAST) begin
            r_rx_cnt   <= 16'd0;
            r_rx_state <= r_rx_sync ? S_IDLE : S_DATA;
          end else begin
            r_rx_cnt <= r_rx_cnt + 16'd1;
          end
        end
        S_DATA: begin
          if (w_rx_bit_end) begin
            r_rx_cnt   <= 16'd0;
            r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
            if (r_rx_bit == 3'd7) begin
              r_rx_state <= S_STOP;
            end else begin
              r_rx_bit <= r_rx_bit + 3'd1;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt + 16'd1;
          end
        end
        S_STOP: begin
          if (w_rx_bit_end) begin
            r_rx_state <= S_IDLE;
            r_rx_cnt   <= 16'd0;
            if (r_rx_sync) begin
              r_rx_data  <= r_rx_shift;
              r_rx_valid <= 1'b1;
            end else begin
              r_rx_ferr <= 1'b1;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt + 16'd1;
          end
        end
        default: begin
          r_rx_state <= S_IDLE;
        end
      endcase
    end
  end
`else
  logic w_unused_ser_rx;

  assign w_unused_ser_rx = ser_rx;
  assign rx_data         = 8'h00;
  assign rx_valid        = 1'b0;
  assign rx_frame_err    = 1'b0;
`endif

endmodule

// File: tb/tb_tbuart.sv
// Directed bench for tbuart at CLKS_PER_BIT=4: TX framing/handshake, reset abort,
// and (with TBUART_RX_EN) loopback, glitch rejection and framing error.
module tb_tbuart;
  localparam int CPB = 4;
`ifdef TBUART_RX_EN
  localparam bit RX_EN = 1'b1;
`else
  localparam bit RX_EN = 1'b0;
`endif

  logic       clock;
  logic       resetb;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       ser_tx;
  logic       tx_busy;
  logic       tx_clear_req;
  logic       ser_rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       loop_en;
  logic       drv_rx;

  int n_checks = 0;
  int n_err    = 0;
  int n_clear  = 0;
  int n_valid  = 0;
  int n_ferr   = 0;

  assign ser_rx = loop_en ? ser_tx : drv_rx;

  tbuart #(.CLKS_PER_BIT(CPB)) dut (
    .clock        (clock),
    .resetb       (resetb),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .ser_tx       (ser_tx),
    .tx_busy      (tx_busy),
    .tx_clear_req (tx_clear_req),
    .ser_rx       (ser_rx),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Pulse counters sampled on the inactive edge.
  always @(negedge clock) begin
    if (tx_clear_req) n_clear = n_clear + 1;
    if (rx_valid)     n_valid = n_valid + 1;
    if (rx_frame_err) n_ferr  = n_ferr + 1;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) else begin
      n_err = n_err + 1;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called right after the edge that starts a frame; ends on the edge busy falls.
  task automatic tx_frame_chk(input string tag, input logic [9:0] frame);
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < CPB; c++) begin
        chk($sformatf("%s ser_tx bit%0d", tag, b), {31'd0, ser_tx}, {31'd0, frame[b]});
        chk($sformatf("%s busy bit%0d", tag, b), {31'd0, tx_busy}, 32'd1);
        chk($sformatf("%s clear bit%0d", tag, b), {31'd0, tx_clear_req}, 32'd0);
        tick();
      end
    end
    chk({tag, " busy end"}, {31'd0, tx_busy}, 32'd0);
    chk({tag, " clear end"}, {31'd0, tx_clear_req}, 32'd1);
    chk({tag, " ser_tx end"}, {31'd0, ser_tx}, 32'd1);
  endtask

  task automatic rx_drive(input logic [7:0] data, input logic stop_bit);
    drv_rx = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      drv_rx = data[i];
      repeat (CPB) tick();
    end
    drv_rx = stop_bit;
    repeat (CPB) tick();
    drv_rx = 1'b1;
  endtask

  initial begin
    resetb   = 1'b0;
    tx_start = 1'b0;
    tx_data  = 8'h00;
    loop_en  = 1'b0;
    drv_rx   = 1'b1;
    repeat (3) tick();

    chk("rst ser_tx", {31'd0, ser_tx}, 32'd1);
    chk("rst busy", {31'd0, tx_busy}, 32'd0);
    chk("rst clear", {31'd0, tx_clear_req}, 32'd0);
    chk("rst rx_data", {24'd0, rx_data}, 32'd0);
    chk("rst rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst rx_ferr", {31'd0, rx_frame_err}, 32'd0);

    resetb = 1'b1;
    tick();

    // Held request: one frame of 0x3D, later tx_data changes ignored.
    tx_start = 1'b1;
    tx_data  = 8'h3D;
    tick();
    tx_data = 8'hC2;
    tx_frame_chk("f3D", 10'b1001111010);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("held busy %0d", i), {31'd0, tx_busy}, 32'd0);
      chk($sformatf("held ser_tx %0d", i), {31'd0, ser_tx}, 32'd1);
    end
    chk("clear count 1", n_clear, 32'd1);

    // Re-arm with one low cycle, then 0x0F.
    tx_start = 1'b0;
    tick();
    tx_start = 1'b1;
    tx_data  = 8'h0F;
    tick();
    tx_data = 8'hF0;
    tx_frame_chk("f0F", 10'b1000011110);
    repeat (2) tick();
    chk("clear count 2", n_clear, 32'd2);

    // Reset during data bit 3 of 0x55 with loopback active.
    loop_en  = 1'b1;
    tx_start = 1'b0;
    tx_data  = 8'h55;
    tick();
    tx_start = 1'b1;
    tick();
    repeat (17) tick();
    chk("abort pre ser_tx", {31'd0, ser_tx}, 32'd0);
    chk("abort pre busy", {31'd0, tx_busy}, 32'd1);
    resetb = 1'b0;
    tick();
    chk("abort ser_tx", {31'd0, ser_tx}, 32'd1);
    chk("abort busy", {31'd0, tx_busy}, 32'd0);
    chk("abort clear", {31'd0, tx_clear_req}, 32'd0);
    tx_start = 1'b0;
    tick();
    resetb = 1'b1;
    repeat (2) tick();
    chk("abort clear count", n_clear, 32'd2);
    chk("abort valid count", n_valid, 32'd0);
    chk("abort ferr count", n_ferr, 32'd0);

    // Fresh full frame 0xA5, looped back into the receiver.
    tx_data  = 8'hA5;
    tx_start = 1'b1;
    tick();
    tx_frame_chk("fA5", 10'b1101001010);
    tx_start = 1'b0;
    repeat (4) tick();
    chk("clear count 3", n_clear, 32'd3);
    chk("loop valid count", n_valid, RX_EN ? 32'd1 : 32'd0);
    chk("loop rx_data", {24'd0, rx_data}, RX_EN ? 32'hA5 : 32'h0);
    chk("loop ferr count", n_ferr, 32'd0);

    // One-cycle glitch on the receive line.
    loop_en = 1'b0;
    drv_rx  = 1'b0;
    tick();
    drv_rx = 1'b1;
    repeat (12) tick();
    chk("glitch valid count", n_valid, RX_EN ? 32'd1 : 32'd0);
    chk("glitch ferr count", n_ferr, 32'd0);

    // 0x3C with a low stop bit.
    rx_drive(8'h3C, 1'b0);
    repeat (8) tick();
    chk("ferr count", n_ferr, RX_EN ? 32'd1 : 32'd0);
    chk("ferr valid count", n_valid, RX_EN ? 32'd1 : 32'd0);
    chk("ferr rx_data", {24'd0, rx_data}, RX_EN ? 32'hA5 : 32'h0);

    // Good frame afterwards shows the receiver recovered.
    rx_drive(8'hC3, 1'b1);
    repeat (8) tick();
    chk("good valid count", n_valid, RX_EN ? 32'd2 : 32'd0);
    chk("good rx_data", {24'd0, rx_data}, RX_EN ? 32'hC3 : 32'h0);
    chk("good ferr count", n_ferr, RX_EN ? 32'd1 : 32'd0);
    chk("tx idle at end", {31'd0, ser_tx}, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/tbuart.md
TBUART -- requirements
Module: tbuart

Interface
REQ-001 Parameter CLKS_PER_BIT, default 4167, clock cycles per UART bit (40 MHz / 9600 baud); legal range 4..65535.
REQ-002 clock  input  1  sole clock; all state updates on rising edge.
REQ-003 resetb  input  1  reset, synchronous, active-low.
REQ-004 tx_start  input  1  transmit request level from driver.
REQ-005 tx_data  input  8  byte to transmit, captured at frame start.
REQ-006 ser_tx  output  1  serial transmit line, idle high.
REQ-007 tx_busy  output  1  high while a transmit frame is in progress.
REQ-008 tx_clear_req  output  1  one-cycle pulse at end of transmit frame.
REQ-009 ser_rx  input  1  serial receive line, asynchronous, idle high.
REQ-010 rx_data  output  8  last correctly received byte.
REQ-011 rx_valid  output  1  one-cycle pulse when rx_data updates.
REQ-012 rx_frame_err  output  1  one-cycle pulse when a stop bit samples low.

Function
REQ-013 Frame format SHALL be 8N1: start bit 0, 8 data bits LSB first, stop bit 1, each bit exactly CLKS_PER_BIT cycles.
REQ-014 TX states SHALL be IDLE, START, DATA, STOP; IDLE->START when tx_start=1 and armed; START->DATA->STOP after 1, 8 and 1 bit times; STOP->IDLE.
REQ-015 Internal armed flag SHALL clear on IDLE->START and set on any cycle tx_start=0; a held tx_start SHALL produce exactly one frame.
REQ-016 On IDLE->START, tx_data SHALL be latched; later tx_data changes SHALL not affect the frame.
REQ-017 tx_busy SHALL be registered, rise on the clock edge where tx_start=1 is sampled with armed=1 (1-cycle latency), and stay high for exactly 10*CLKS_PER_BIT cycles.
REQ-018 ser_tx SHALL go low on the same edge tx_busy rises; ser_tx SHALL be high whenever tx_busy=0.
REQ-019 tx_clear_req SHALL pulse high for one cycle on the edge tx_busy falls.
REQ-020 ser_rx SHALL pass through a 2-flop synchronizer before use.
REQ-021 RX states SHALL be IDLE, START, DATA, STOP; IDLE->START on synchronized high-to-low transition.
REQ-022 Start bit SHALL be resampled at CLKS_PER_BIT/2 cycles (integer floor); if high, return to IDLE with no output (glitch rejection).
REQ-023 Data and stop bits SHALL be sampled every CLKS_PER_BIT cycles after the start midpoint.
REQ-024 Stop sample 1: rx_data updates and rx_valid pulses one cycle; stop sample 0: rx_frame_err pulses one cycle and rx_data holds its value.
REQ-025 After the stop sample, RX SHALL return to IDLE; a new start edge SHALL be accepted from the next cycle.
REQ-026 TX and RX SHALL operate independently and concurrently, including loopback of ser_tx into ser_rx.

Reset
REQ-027 With resetb=0 at a clock edge: ser_tx=1, tx_busy=0, tx_clear_req=0, rx_data=0, rx_valid=0, rx_frame_err=0, both FSMs IDLE, armed=1, synchronizer flops=1.
REQ-028 Reset mid-frame SHALL abort the frame without a tx_clear_req, rx_valid or rx_frame_err pulse.

Configuration
REQ-029 Macro TBUART_RX_EN defined: receiver present per REQ-020..025.
REQ-030 Macro TBUART_RX_EN undefined: no receiver logic; ser_rx ignored; rx_data=0, rx_valid=0, rx_frame_err=0 constantly; TX unchanged.

Verification
REQ-031 CLKS_PER_BIT=4, tx_start=1 held, tx_data=61 (0x3D) -> ser_tx 0,1,0,1,1,1,1,0,0,1 per 4-cycle bit; tx_busy high 40 cycles; one tx_clear_req pulse; no second frame while tx_start stays high.
REQ-032 After REQ-031, tx_start=0 for 1 cycle then 1 with tx_data=15 -> second frame 0,1,1,1,1,0,0,0,0,1.
REQ-033 TBUART_RX_EN, ser_tx looped to ser_rx, send 0xA5 -> rx_valid pulses once with rx_data=0xA5, rx_frame_err=0.
REQ-034 ser_rx low for 1 cycle only -> no rx_valid, no rx_frame_err, RX back in IDLE.
REQ-035 Drive frame 0x3C with stop bit 0 -> rx_frame_err pulses once, rx_valid stays 0, rx_data unchanged.
REQ-036 resetb=0 during DATA bit 3 -> ser_tx=1, tx_busy=0 on that edge, no tx_clear_req; fresh tx_start after release sends full frame.
